// File: rtl/shift_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_pkg
// Description : Shared types and constants for the 4-bit shift-register link
//               (PISO transmitter and SIPO receiver).
// Revision    : 1.0 - initial release
// ============================================================================
package shift_reg_pkg;

    // Frame sequencer states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Default word length shared by both ends of the link
    localparam int SHIFT_WIDTH = 4;

    // Bit order on the wire: 1 = MSB first
    localparam bit MSB_FIRST = 1'b1;

endpackage : shift_reg_pkg
`default_nettype wire

// File: rtl/shift_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : shift_bit_counter
// Description : Loadable down-counter with zero flag; saturates at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_bit_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] r_count;

    // Decrement is gated on non-zero so the count can never wrap.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count = r_count;
    assign zero  = (r_count == '0);

endmodule : shift_bit_counter
`default_nettype wire

// File: rtl/register_shift_piso_4_bit_tx.sv
`default_nettype none
// ============================================================================
// Module      : register_shift_piso_4_bit_tx
// Description : Parallel-in/serial-out transmitter with valid/ready load and
//               gap-free back-to-back framing.
// Revision    : 1.0 - initial release
// ============================================================================
module register_shift_piso_4_bit_tx
    import shift_reg_pkg::*;
#(
    parameter  int WIDTH = SHIFT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic             w_out_bit;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_zero;
    logic             w_in_shift;
    logic             w_last;
    logic             w_load;

    assign w_in_shift = (r_state == SHIFT);
    assign w_last     = w_in_shift && w_cnt_zero;
    assign load_ready = (r_state == IDLE) || w_last;
    assign w_load     = load_valid && load_ready;

    shift_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk        (clk),
        .clear_n    (clear_n),
        .load       (w_load),
        .load_value (c_LAST_IDX),
        .dec        (w_in_shift && !w_load),
        .count      (w_cnt),
        .zero       (w_cnt_zero)
    );

    // Zero fill means the register is empty once the last bit has left.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shift_next = {r_shift[WIDTH-2:0], 1'b0};
            assign w_out_bit    = r_shift[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shift_next = {1'b0, r_shift[WIDTH-1:1]};
            assign w_out_bit    = r_shift[0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            r_shift <= '0;
        end else if (w_load) begin
            r_shift <= parallel_in;
        end else if (w_in_shift) begin
            r_shift <= w_shift_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_load) w_state_next = SHIFT;
            end
            SHIFT: begin
                if (w_load)          w_state_next = SHIFT;
                else if (w_cnt_zero) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign serial_out   = w_out_bit;
    assign serial_valid = w_in_shift;
    assign busy         = w_in_shift;
    assign last_bit     = w_last;

    // w_cnt is only consumed through the zero flag; keep it observable.
    logic w_unused_cnt;
    assign w_unused_cnt = ^w_cnt;

endmodule : register_shift_piso_4_bit_tx
`default_nettype wire
